// File: rtl/wishbone_bus_arbiter.sv
// Two-master / one-slave Wishbone arbiter for the CPU data (m0) and
// instruction (m1) ports. A master keeps the bus for its whole cyc
// assertion. A watchdog ends slave accesses that never ack by returning err.
//
// state | meaning
// ------+-------------------------------------------------------------
// IDLE  | no owner; the slave sees no cyc/stb
// GNT0  | data master m0 owns the slave bus until m0_cyc_i falls
// GNT1  | instruction master m1 owns the slave bus until m1_cyc_i falls
module wishbone_bus_arbiter #(
    parameter int ARB_MODE       = 0,
    parameter int TIMEOUT_CYCLES = 255,
    parameter int TO_W           = 8
) (
    input  logic        clk,
    input  logic        rst,

    input  logic [31:0] m0_addr_i,
    input  logic [31:0] m0_data_i,
    input  logic [3:0]  m0_sel_i,
    input  logic        m0_we_i,
    input  logic        m0_stb_i,
    input  logic        m0_cyc_i,
    output logic [31:0] m0_data_o,
    output logic        m0_ack_o,
    output logic        m0_err_o,

    input  logic [31:0] m1_addr_i,
    input  logic [31:0] m1_data_i,
    input  logic [3:0]  m1_sel_i,
    input  logic        m1_we_i,
    input  logic        m1_stb_i,
    input  logic        m1_cyc_i,
    output logic [31:0] m1_data_o,
    output logic        m1_ack_o,
    output logic        m1_err_o,

    input  logic [31:0] s_data_i,
    input  logic        s_ack_i,
    output logic [31:0] s_addr_o,
    output logic [31:0] s_data_o,
    output logic [3:0]  s_sel_o,
    output logic        s_we_o,
    output logic        s_stb_o,
    output logic        s_cyc_o,

    output logic [1:0]  grant_o
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        GNT0 = 2'd1,
        GNT1 = 2'd2
    } state_t;

    localparam logic            WD_EN    = (TIMEOUT_CYCLES != 0);
    localparam logic [TO_W-1:0] WD_LIMIT = TO_W'(TIMEOUT_CYCLES);
    localparam logic [TO_W-1:0] WD_ONE   = TO_W'(1);

    state_t          state_q;
    state_t          state_d;
    logic            last_grant_q;   // 1 = m1 was granted most recently
    logic [TO_W-1:0] wd_q;

    logic            own0;
    logic            own1;
    logic            owner_stb;
    logic            wd_hit;

    // Owner decode and watchdog terminal-count detect
    always_comb begin
        own0      = (state_q == GNT0);
        own1      = (state_q == GNT1);
        owner_stb = (own0 & m0_stb_i) | (own1 & m1_stb_i);
        wd_hit    = WD_EN & owner_stb & (wd_q == WD_LIMIT);
    end

    // Next-state: tie-break from IDLE, direct hand-over on release, no preemption
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (m0_cyc_i && m1_cyc_i) begin
                    if (ARB_MODE == 0) state_d = GNT0;
                    else               state_d = last_grant_q ? GNT0 : GNT1;
                end else if (m0_cyc_i) begin
                    state_d = GNT0;
                end else if (m1_cyc_i) begin
                    state_d = GNT1;
                end
            end
            GNT0: if (!m0_cyc_i) state_d = m1_cyc_i ? GNT1 : IDLE;
            GNT1: if (!m1_cyc_i) state_d = m0_cyc_i ? GNT0 : IDLE;
            default: state_d = IDLE;
        endcase
    end

    // State, registered grant, last-grant history and watchdog counter
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            last_grant_q <= 1'b1;
            wd_q         <= '0;
            grant_o      <= 2'b00;
        end else begin
            state_q <= state_d;
            grant_o <= {state_d == GNT1, state_d == GNT0};
            if (state_d != state_q && state_d != IDLE)
                last_grant_q <= (state_d == GNT1);
            if (!WD_EN || state_d != state_q || !owner_stb || s_ack_i || wd_hit)
                wd_q <= '0;
            else
                wd_q <= wd_q + WD_ONE;
        end
    end

    // Bus steering. On the watchdog cycle stb is dropped unconditionally so
    // s_stb_o never depends on s_ack_i (slaves often derive ack from stb).
    always_comb begin
        s_addr_o  = '0;
        s_data_o  = '0;
        s_sel_o   = '0;
        s_we_o    = 1'b0;
        s_cyc_o   = 1'b0;
        s_stb_o   = 1'b0;
        m0_data_o = '0;
        m0_ack_o  = 1'b0;
        m0_err_o  = 1'b0;
        m1_data_o = '0;
        m1_ack_o  = 1'b0;
        m1_err_o  = 1'b0;
        if (own0) begin
            s_addr_o  = m0_addr_i;
            s_data_o  = m0_data_i;
            s_sel_o   = m0_sel_i;
            s_we_o    = m0_we_i;
            s_cyc_o   = m0_cyc_i;
            s_stb_o   = m0_stb_i & ~wd_hit;
            m0_data_o = s_data_i;
            m0_ack_o  = s_ack_i;
            m0_err_o  = wd_hit & ~s_ack_i;
        end else if (own1) begin
            s_addr_o  = m1_addr_i;
            s_data_o  = m1_data_i;
            s_sel_o   = m1_sel_i;
            s_we_o    = m1_we_i;
            s_cyc_o   = m1_cyc_i;
            s_stb_o   = m1_stb_i & ~wd_hit;
            m1_data_o = s_data_i;
            m1_ack_o  = s_ack_i;
            m1_err_o  = wd_hit & ~s_ack_i;
        end
    end

endmodule

// File: tb/tb_wishbone_bus_arbiter.sv
// Bench for wishbone_bus_arbiter: a fixed-priority and a round-robin
// instance share one set of master/slave stimulus and are compared every
// cycle against a behavioural model of ownership, plus directed checks.
module tb_wishbone_bus_arbiter;

    localparam int TMO = 4;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic        m_cyc  [2];
    logic        m_stb  [2];
    logic        m_we   [2];
    logic [31:0] m_addr [2];
    logic [31:0] m_wdat [2];
    logic [3:0]  m_sel  [2];
    logic        s_ack;
    logic [31:0] s_rdat;

    // r_*[k]: outputs of instance k (0 = fixed priority, 1 = round robin)
    logic [31:0] r_mdat [2][2];
    logic        r_mack [2][2];
    logic        r_merr [2][2];
    logic [31:0] r_saddr [2];
    logic [31:0] r_sdat  [2];
    logic [3:0]  r_ssel  [2];
    logic        r_swe   [2];
    logic        r_sstb  [2];
    logic        r_scyc  [2];
    logic [1:0]  r_gnt   [2];

    wishbone_bus_arbiter #(.ARB_MODE(0), .TIMEOUT_CYCLES(TMO), .TO_W(8)) dut_fp (
        .clk(clk), .rst(rst),
        .m0_addr_i(m_addr[0]), .m0_data_i(m_wdat[0]), .m0_sel_i(m_sel[0]),
        .m0_we_i(m_we[0]), .m0_stb_i(m_stb[0]), .m0_cyc_i(m_cyc[0]),
        .m0_data_o(r_mdat[0][0]), .m0_ack_o(r_mack[0][0]), .m0_err_o(r_merr[0][0]),
        .m1_addr_i(m_addr[1]), .m1_data_i(m_wdat[1]), .m1_sel_i(m_sel[1]),
        .m1_we_i(m_we[1]), .m1_stb_i(m_stb[1]), .m1_cyc_i(m_cyc[1]),
        .m1_data_o(r_mdat[0][1]), .m1_ack_o(r_mack[0][1]), .m1_err_o(r_merr[0][1]),
        .s_data_i(s_rdat), .s_ack_i(s_ack),
        .s_addr_o(r_saddr[0]), .s_data_o(r_sdat[0]), .s_sel_o(r_ssel[0]),
        .s_we_o(r_swe[0]), .s_stb_o(r_sstb[0]), .s_cyc_o(r_scyc[0]),
        .grant_o(r_gnt[0])
    );

    wishbone_bus_arbiter #(.ARB_MODE(1), .TIMEOUT_CYCLES(TMO), .TO_W(8)) dut_rr (
        .clk(clk), .rst(rst),
        .m0_addr_i(m_addr[0]), .m0_data_i(m_wdat[0]), .m0_sel_i(m_sel[0]),
        .m0_we_i(m_we[0]), .m0_stb_i(m_stb[0]), .m0_cyc_i(m_cyc[0]),
        .m0_data_o(r_mdat[1][0]), .m0_ack_o(r_mack[1][0]), .m0_err_o(r_merr[1][0]),
        .m1_addr_i(m_addr[1]), .m1_data_i(m_wdat[1]), .m1_sel_i(m_sel[1]),
        .m1_we_i(m_we[1]), .m1_stb_i(m_stb[1]), .m1_cyc_i(m_cyc[1]),
        .m1_data_o(r_mdat[1][1]), .m1_ack_o(r_mack[1][1]), .m1_err_o(r_merr[1][1]),
        .s_data_i(s_rdat), .s_ack_i(s_ack),
        .s_addr_o(r_saddr[1]), .s_data_o(r_sdat[1]), .s_sel_o(r_ssel[1]),
        .s_we_o(r_swe[1]), .s_stb_o(r_sstb[1]), .s_cyc_o(r_scyc[1]),
        .grant_o(r_gnt[1])
    );

    // Reference model per instance: owner (-1 none), last owner, stall count
    int owner [2];
    int last  [2];
    int stall [2];
    int tests = 0;
    int fails = 0;

    task automatic chk(input string tag, input int k, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s dut%0d observed %h expected %h", tag, k, obs, exp);
        end
    endtask

    task automatic check_all();
        for (int k = 0; k < 2; k++) begin
            int          o;
            logic        hit;
            logic [1:0]  eg;
            logic [31:0] ea, ed;
            logic [3:0]  es;
            logic        ewe, estb, ecyc;
            logic [31:0] emd  [2];
            logic        eack [2];
            logic        eerr [2];
            o = owner[k];
            hit = 1'b0; eg = 2'b00; ea = '0; ed = '0; es = '0;
            ewe = 1'b0; estb = 1'b0; ecyc = 1'b0;
            for (int j = 0; j < 2; j++) begin
                emd[j] = '0; eack[j] = 1'b0; eerr[j] = 1'b0;
            end
            if (o >= 0) begin
                hit  = (stall[k] == TMO) && m_stb[o];
                eg   = (o == 0) ? 2'b01 : 2'b10;
                ea   = m_addr[o];
                ed   = m_wdat[o];
                es   = m_sel[o];
                ewe  = m_we[o];
                ecyc = m_cyc[o];
                estb = m_stb[o] && !hit;
                emd[o]  = s_rdat;
                eack[o] = s_ack;
                eerr[o] = hit && !s_ack;
            end
            chk("grant", k, 32'(r_gnt[k]), 32'(eg));
            chk("s_addr", k, r_saddr[k], ea);
            chk("s_data", k, r_sdat[k], ed);
            chk("s_sel", k, 32'(r_ssel[k]), 32'(es));
            chk("s_we", k, 32'(r_swe[k]), 32'(ewe));
            chk("s_cyc", k, 32'(r_scyc[k]), 32'(ecyc));
            chk("s_stb", k, 32'(r_sstb[k]), 32'(estb));
            for (int j = 0; j < 2; j++) begin
                chk($sformatf("m%0d_data", j), k, r_mdat[k][j], emd[j]);
                chk($sformatf("m%0d_ack", j), k, 32'(r_mack[k][j]), 32'(eack[j]));
                chk($sformatf("m%0d_err", j), k, 32'(r_merr[k][j]), 32'(eerr[j]));
            end
        end
    endtask

    task automatic model_update();
        for (int k = 0; k < 2; k++) begin
            int   o, n;
            logic so, hit;
            o   = owner[k];
            so  = (o >= 0) ? m_stb[o] : 1'b0;
            hit = (o >= 0) && (stall[k] == TMO) && so;
            if (rst) begin
                owner[k] = -1;
                last[k]  = 1;
                stall[k] = 0;
            end else begin
                if (o < 0) begin
                    if (m_cyc[0] && m_cyc[1]) n = (k == 0) ? 0 : 1 - last[k];
                    else if (m_cyc[0])        n = 0;
                    else if (m_cyc[1])        n = 1;
                    else                      n = -1;
                end else if (!m_cyc[o]) begin
                    n = m_cyc[1 - o] ? 1 - o : -1;
                end else begin
                    n = o;
                end
                if (n != o || !so || s_ack || hit) stall[k] = 0;
                else                               stall[k] = stall[k] + 1;
                if (n >= 0 && n != o) last[k] = n;
                owner[k] = n;
            end
        end
    endtask

    task automatic drive(input int j, input logic cyc, input logic stb, input logic [31:0] addr);
        m_cyc[j]  = cyc;
        m_stb[j]  = stb;
        m_addr[j] = addr;
        m_wdat[j] = $urandom;
        m_sel[j]  = 4'($urandom);
        m_we[j]   = 1'($urandom);
    endtask

    task automatic settle();
        #3;
        check_all();
    endtask

    task automatic adv();
        @(posedge clk);
        #1;
        model_update();
    endtask

    initial begin
        #1_000_000;
        $display("FAIL global_timeout: bench did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        for (int k = 0; k < 2; k++) begin
            owner[k] = -1; last[k] = 1; stall[k] = 0;
        end
        rst = 1'b1;
        drive(0, 1'b0, 1'b0, 32'h0);
        drive(1, 1'b0, 1'b0, 32'h0);
        s_ack  = 1'b0;
        s_rdat = 32'h0;
        adv();

        // Reset state
        settle();
        for (int k = 0; k < 2; k++) begin
            chk("rst_grant", k, 32'(r_gnt[k]), 32'h0);
            chk("rst_scyc", k, 32'(r_scyc[k]), 32'h0);
            chk("rst_sstb", k, 32'(r_sstb[k]), 32'h0);
            chk("rst_m0_ack", k, 32'(r_mack[k][0]), 32'h0);
        end
        adv();
        rst = 1'b0;

        // m1 alone; slave acks two cycles after stb
        drive(1, 1'b1, 1'b1, 32'hBFC0_0000);
        settle();
        for (int k = 0; k < 2; k++) begin
            chk("t1_latency_grant", k, 32'(r_gnt[k]), 32'h0);
            chk("t1_latency_scyc", k, 32'(r_scyc[k]), 32'h0);
        end
        adv();
        settle();
        for (int k = 0; k < 2; k++) begin
            chk("t1_grant", k, 32'(r_gnt[k]), 32'h2);
            chk("t1_saddr", k, r_saddr[k], 32'hBFC0_0000);
        end
        adv();
        settle();
        adv();
        s_ack = 1'b1; s_rdat = 32'h3C1D_0001;
        settle();
        for (int k = 0; k < 2; k++) begin
            chk("t1_m1_ack", k, 32'(r_mack[k][1]), 32'h1);
            chk("t1_m1_data", k, r_mdat[k][1], 32'h3C1D_0001);
            chk("t1_m0_ack", k, 32'(r_mack[k][0]), 32'h0);
        end
        adv();
        s_ack = 1'b0;
        drive(1, 1'b0, 1'b0, 32'h0);
        settle(); adv();
        settle();
        for (int k = 0; k < 2; k++) chk("t1_release_idle", k, 32'(r_gnt[k]), 32'h0);
        adv();

        // Simultaneous request, then hand-over with no idle cycle
        drive(0, 1'b1, 1'b1, 32'h0000_1000);
        drive(1, 1'b1, 1'b1, 32'h0000_2000);
        settle(); adv();
        s_ack = 1'b1; s_rdat = $urandom;
        settle();
        for (int k = 0; k < 2; k++) chk("t2_first_grant", k, 32'(r_gnt[k]), 32'h1);
        adv();
        s_ack = 1'b0;
        drive(0, 1'b0, 1'b0, 32'h0);
        settle();
        for (int k = 0; k < 2; k++) chk("t2_release_cycle", k, 32'(r_gnt[k]), 32'h1);
        adv();
        settle();
        for (int k = 0; k < 2; k++) chk("t2_handover", k, 32'(r_gnt[k]), 32'h2);

        // m1 holds cyc while m0 requests: no preemption, no ack to m0
        adv();
        drive(0, 1'b1, 1'b1, 32'h0000_3000);
        s_ack = 1'b1;
        for (int i = 0; i < 3; i++) begin
            s_rdat = $urandom;
            settle();
            for (int k = 0; k < 2; k++) begin
                chk("t4_hold_grant", k, 32'(r_gnt[k]), 32'h2);
                chk("t4_m0_noack", k, 32'(r_mack[k][0]), 32'h0);
            end
            adv();
        end
        s_ack = 1'b0;
        drive(1, 1'b0, 1'b0, 32'h0);
        settle(); adv();
        settle();
        for (int k = 0; k < 2; k++) chk("t4_after_release", k, 32'(r_gnt[k]), 32'h1);
        adv();
        drive(0, 1'b0, 1'b0, 32'h0);
        settle(); adv();

        // Tie from IDLE after m0 was last: policies diverge
        drive(0, 1'b1, 1'b1, 32'h0000_4000);
        drive(1, 1'b1, 1'b1, 32'h0000_5000);
        settle(); adv();
        settle();
        chk("tie_fixed", 0, 32'(r_gnt[0]), 32'h1);
        chk("tie_rr", 1, 32'(r_gnt[1]), 32'h2);
        adv();
        drive(0, 1'b0, 1'b0, 32'h0);
        drive(1, 1'b0, 1'b0, 32'h0);
        settle(); adv();

        // Reset in GNT0 with an in-flight ack
        drive(0, 1'b1, 1'b1, 32'h1000_0000);
        settle(); adv();
        settle(); adv();
        settle(); adv();
        rst = 1'b1; s_ack = 1'b1; s_rdat = $urandom;
        settle(); adv();
        rst = 1'b0;
        settle();
        for (int k = 0; k < 2; k++) begin
            chk("t6_grant", k, 32'(r_gnt[k]), 32'h0);
            chk("t6_scyc", k, 32'(r_scyc[k]), 32'h0);
            chk("t6_ack_dropped", k, 32'(r_mack[k][0]), 32'h0);
        end
        adv();

        // Watchdog: err on the 5th owned cycle (4 after stb rises); this also
        // shows the counter restarted from zero after the reset above
        s_ack = 1'b0;
        for (int i = 0; i < TMO; i++) begin
            settle();
            for (int k = 0; k < 2; k++) begin
                chk("t5_pre_err", k, 32'(r_merr[k][0]), 32'h0);
                chk("t5_pre_stb", k, 32'(r_sstb[k]), 32'h1);
            end
            adv();
        end
        settle();
        for (int k = 0; k < 2; k++) begin
            chk("t5_err", k, 32'(r_merr[k][0]), 32'h1);
            chk("t5_stb_forced", k, 32'(r_sstb[k]), 32'h0);
            chk("t5_no_ack", k, 32'(r_mack[k][0]), 32'h0);
            chk("t5_grant_kept", k, 32'(r_gnt[k]), 32'h1);
        end
        adv();
        for (int i = 0; i < TMO; i++) begin
            settle();
            for (int k = 0; k < 2; k++) chk("t5b_pre_err", k, 32'(r_merr[k][0]), 32'h0);
            adv();
        end
        s_ack = 1'b1; s_rdat = 32'hCAFE_F00D;
        settle();
        for (int k = 0; k < 2; k++) begin
            chk("t5b_late_ack", k, 32'(r_mack[k][0]), 32'h1);
            chk("t5b_late_noerr", k, 32'(r_merr[k][0]), 32'h0);
            chk("t5b_late_data", k, r_mdat[k][0], 32'hCAFE_F00D);
        end
        adv();
        s_ack = 1'b0;
        drive(0, 1'b0, 1'b0, 32'h0);
        settle(); adv();

        // Round robin over four single-access tenures after a reset
        rst = 1'b1;
        settle(); adv();
        rst = 1'b0;
        for (int i = 0; i < 4; i++) begin
            int e;
            e = i % 2;
            drive(0, 1'b1, 1'b1, 32'h2000_0000 + 32'(i));
            drive(1, 1'b1, 1'b1, 32'h3000_0000 + 32'(i));
            if (i == 0) begin
                settle(); adv();
            end
            s_ack = 1'b1; s_rdat = $urandom;
            settle();
            chk("t3_rr_order", 1, 32'(r_gnt[1]), (e == 0) ? 32'h1 : 32'h2);
            adv();
            s_ack = 1'b0;
            drive(e, 1'b0, 1'b0, 32'h0);
            settle(); adv();
        end
        drive(0, 1'b0, 1'b0, 32'h0);
        drive(1, 1'b0, 1'b0, 32'h0);
        settle(); adv();

        // Randomised traffic against the model
        for (int i = 0; i < 600; i++) begin
            for (int j = 0; j < 2; j++) begin
                logic c;
                c = m_cyc[j];
                if (c) c = ($urandom_range(3) != 0);
                else   c = ($urandom_range(2) == 0);
                drive(j, c, c && ($urandom_range(3) != 0), $urandom);
            end
            s_ack  = ($urandom_range(5) == 0);
            s_rdat = $urandom;
            rst    = ($urandom_range(99) == 0);
            settle();
            adv();
        end
        rst = 1'b0;

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/wishbone_bus_arbiter.md
Name: wishbone_bus_arbiter

Overview:
Two-master, one-slave Wishbone arbiter that shares the single external memory/peripheral bus between the CPU's data port (m0) and instruction port (m1). It sits between the two bus-interface units and the SoC slave fabric. Each granted tenure lasts for the master's whole cyc assertion. A watchdog terminates hung cycles with an error strobe.

Parameters:
ARB_MODE, 0, 0 = fixed priority (m0 wins); 1 = round-robin (the master not granted last wins on a tie)
TIMEOUT_CYCLES, 255, consecutive stb-without-ack cycles before err is returned; 0 disables the watchdog
TO_W, 8, width of the watchdog counter; must satisfy TIMEOUT_CYCLES < 2^TO_W

Ports:
clk  in  1  system clock
rst  in  1  synchronous, active-high reset
m0_addr_i  in  32  data master address
m0_data_i  in  32  data master write data
m0_sel_i  in  4  data master byte select
m0_we_i  in  1  data master write enable
m0_stb_i  in  1  data master strobe
m0_cyc_i  in  1  data master cycle
m0_data_o  out  32  read data to the data master
m0_ack_o  out  1  ack to the data master
m0_err_o  out  1  timeout error to the data master
m1_addr_i, m1_data_i, m1_sel_i, m1_we_i, m1_stb_i, m1_cyc_i  in  32/32/4/1/1/1  instruction master, same meanings as m0
m1_data_o  out  32  read data to the instruction master
m1_ack_o  out  1  ack to the instruction master
m1_err_o  out  1  timeout error to the instruction master
s_data_i  in  32  slave read data
s_ack_i  in  1  slave ack
s_addr_o  out  32  slave address
s_data_o  out  32  slave write data
s_sel_o  out  4  slave byte select
s_we_o  out  1  slave write enable
s_stb_o  out  1  slave strobe
s_cyc_o  out  1  slave cycle
grant_o  out  2  one-hot current owner: 01 = m0, 10 = m1, 00 = idle

Behaviour:
- FSM states: IDLE, GNT0, GNT1. Reset: IDLE, last_grant = m1 (so m0 wins the first round-robin tie), watchdog = 0, grant_o = 00, all s_* outputs 0, all m*_ack/err/data outputs 0.
- IDLE transitions:
  - m0_cyc only -> GNT0.
  - m1_cyc only -> GNT1.
  - Both, ARB_MODE=0 -> GNT0.
  - Both, ARB_MODE=1 -> the master that is not last_grant.
  - Grant latency is 1 cycle: the slave sees no cyc/stb while in IDLE.
- In GNTx:
  - s_* outputs are driven combinationally from master x.
  - s_ack_i is routed to mx_ack_o; the other master's ack and err stay 0.
  - s_data_i is routed to mx_data_o; the non-granted master's data_o is 0.
- Release: at an edge where the owner's cyc is 0:
  - If the other master's cyc = 1 -> move directly to that master's GNT state (no dead cycle).
  - Else -> IDLE.
  - last_grant is updated on every entry to a GNT state.
- No preemption: a request from the other master never interrupts an owner holding cyc, regardless of ARB_MODE.
- Watchdog (TIMEOUT_CYCLES > 0):
  - Increments each cycle in GNTx with owner stb=1 and s_ack_i=0.
  - Clears on s_ack_i, on owner stb=0, and on any state change.
  - When the count equals TIMEOUT_CYCLES: mx_err_o pulses for exactly 1 cycle, mx_ack_o stays 0, s_stb_o is forced 0 that cycle, and the counter clears.
  - The grant is kept until the owner drops cyc.
- Late ack: an s_ack_i arriving in the same cycle as the timeout wins; the access acks and no err is raised.
- The arbiter adds no wait states beyond the 1-cycle grant latency; ack latency equals slave latency.
- Reset asserted mid-tenure: next edge goes to IDLE with all outputs 0. An in-flight slave ack during reset is dropped.

Test Plan:
- Only m1 requests (cyc=stb=1, addr 0xBFC00000); slave acks 2 cycles after s_stb with data 0x3C1D0001 -> grant_o = 10 one cycle after the request; m1_ack_o = 1 and m1_data_o = 0x3C1D0001; m0_ack_o = 0.
- ARB_MODE=0; both masters raise cyc in the same cycle -> GNT0. When m0 drops cyc, the state moves straight to GNT1 at the next edge, with no IDLE cycle.
- ARB_MODE=1; both masters request continuously over 4 tenures of single accesses -> grant order m0, m1, m0, m1.
- m1 owns the bus with a held cyc; m0 requests during the tenure -> no switch until m1_cyc falls, and m0 sees no ack meanwhile.
- TIMEOUT_CYCLES=4; slave never acks -> m0_err_o pulses for 1 cycle, 4 cycles after s_stb rises; s_stb_o = 0 that cycle; m0_ack_o stays 0. Repeat with s_ack_i arriving on the timeout cycle -> ack and no err.
- rst = 1 while in GNT0 -> next edge: grant_o = 00, s_cyc_o = 0, watchdog cleared.
